// File: rtl/inputport_rx_if.sv
// inputport_rx_if: bundle of the receive-stage handshake and status signals.
//   valid_in, din    : asynchronous valid level and bundled data from the input port
//   take             : one-cycle capture pulse back upstream
//   dout, dout_valid : head-of-FIFO word and non-empty flag toward the core
//   dout_ready       : core accepts dout when dout_valid && dout_ready
//   count, full      : FIFO occupancy and full flag
//   overflow         : sticky word-dropped flag
interface inputport_rx_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 3
);
    logic             valid_in;
    logic [WIDTH-1:0] din;
    logic             take;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             overflow;

    modport slave (
        input  valid_in, din, dout_ready,
        output take, dout, dout_valid, count, full, overflow
    );

    modport master (
        output valid_in, din, dout_ready,
        input  take, dout, dout_valid, count, full, overflow
    );
endinterface

// File: rtl/inputport_rx.sv
// inputport_rx: synchronises the input port's valid level, edge-detects it and captures din into an FWFT FIFO.
//   clk_inputport : sole clock, rising edge
//   reset         : synchronous, active-low
//   rx            : slave side of inputport_rx_if (valid_in/din in, dout/dout_valid/dout_ready out to core,
//                   take/count/full/overflow status)
module inputport_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk_inputport,
    input logic          reset,
    inputport_rx_if.slave rx
);
    localparam int AW = $clog2(DEPTH);

    logic             s1_q, s1_d, s2_q, s2_d, s2_dly_q, s2_dly_d;
    logic [1:0]       live_q, live_d;
    logic             arm_q, arm_d;
    logic             take_q, take_d;
    logic             overflow_q, overflow_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             cap, pop, push, drop, empty, is_full;

    // The synchroniser's reset zeros are not real samples of valid_in, so a level that
    // was already high across reset would look like a fresh rise. live_q marks when s2
    // carries a genuine sample; edges are armed only once valid has been seen low after that.
    assign cap     = s2_q & ~s2_dly_q & arm_q;
    assign empty   = count_q == '0;
    assign is_full = count_q == CW'(DEPTH);
    assign pop     = ~empty & rx.dout_ready;
    assign push    = cap & (~is_full | pop);
    assign drop    = cap & is_full & ~pop;

    always_comb begin
        s1_d       = rx.valid_in;
        s2_d       = s1_q;
        s2_dly_d   = s2_q;
        live_d     = {live_q[0], 1'b1};
        arm_d      = arm_q | (live_q[1] & ~s2_q);
        take_d     = cap;
        overflow_d = overflow_q | drop;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_inputport) begin
        if (!reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s2_dly_q   <= 1'b0;
            live_q     <= '0;
            arm_q      <= 1'b0;
            take_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s2_dly_q   <= s2_dly_d;
            live_q     <= live_d;
            arm_q      <= arm_d;
            take_q     <= take_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible through a non-zero count.
    always_ff @(posedge clk_inputport) begin
        if (reset && push) mem_q[wr_ptr_q] <= rx.din;
    end

    assign rx.take       = take_q;
    assign rx.count      = count_q;
    assign rx.full       = is_full;
    assign rx.overflow   = overflow_q;
    assign rx.dout_valid = ~empty;
    assign rx.dout       = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: tb/tb_inputport_rx.sv
// tb_inputport_rx: scenario-task bench for inputport_rx with a queue scoreboard of expected output words.
module tb_inputport_rx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    inputport_rx_if #(.WIDTH(8), .CW(3)) bus ();

    inputport_rx #(.WIDTH(8), .DEPTH(4), .CW(3)) dut (
        .clk_inputport(clk),
        .reset(reset),
        .rx(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, output logic took);
        bus.din = d;
        bus.valid_in = 1'b1;
        repeat (3) tick();
        took = bus.take;
        bus.valid_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            while (!bus.dout_valid && w < 20) begin
                tick();
                w++;
            end
            n_chk++;
            if (!bus.dout_valid || exp_q.size() == 0)
                $display("FAIL drain[%0d]: dout_valid=%b queued=%0d, required valid word", i, bus.dout_valid, exp_q.size());
            else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.dout !== e) $display("FAIL drain[%0d]: dout=%h required %h", i, bus.dout, e);
                else n_pass++;
            end
            bus.dout_ready = 1'b1;
            tick();
            bus.dout_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_chk++;
            if ({bus.count, bus.dout_valid, bus.take, bus.overflow} !== 6'b0)
                $display("FAIL reset_idle[%0d]: count=%0d dv=%b take=%b ovf=%b required all 0", i, bus.count, bus.dout_valid, bus.take, bus.overflow);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        bus.din = 8'hA5;
        bus.valid_in = 1'b1;
        exp_q.push_back(8'hA5);
        repeat (2) tick();
        n_chk++;
        if (bus.take !== 1'b0) $display("FAIL single_take_early: take=%b required 0", bus.take);
        else n_pass++;
        tick();
        n_chk++;
        if ({bus.take, bus.dout_valid, bus.count} !== {1'b1, 1'b1, 3'd1})
            $display("FAIL single_capture: take=%b dv=%b count=%0d required 1 1 1", bus.take, bus.dout_valid, bus.count);
        else n_pass++;
        n_chk++;
        if (bus.dout !== exp_q[0]) $display("FAIL single_dout: dout=%h required %h", bus.dout, exp_q[0]);
        else n_pass++;
        tick();
        n_chk++;
        if (bus.take !== 1'b0) $display("FAIL single_take_len: take=%b required 0", bus.take);
        else n_pass++;
        bus.valid_in = 1'b0;
        repeat (2) tick();
        drain(1);
        n_chk++;
        if ({bus.count, bus.dout_valid, bus.dout} !== {3'd0, 1'b0, 8'h00})
            $display("FAIL single_pop: count=%0d dv=%b dout=%h required 0 0 00", bus.count, bus.dout_valid, bus.dout);
        else n_pass++;
    endtask

    task automatic test_fill_overflow();
        logic took;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_word(8'(i), took);
            n_chk++;
            if (took !== 1'b1) $display("FAIL fill_take[%0d]: take=%b required 1", i, took);
            else n_pass++;
            if (i == 4) begin
                n_chk++;
                if ({bus.full, bus.count, bus.overflow} !== {1'b1, 3'd4, 1'b0})
                    $display("FAIL fill_full: full=%b count=%0d ovf=%b required 1 4 0", bus.full, bus.count, bus.overflow);
                else n_pass++;
            end
        end
        n_chk++;
        if ({bus.overflow, bus.count} !== {1'b1, 3'd4})
            $display("FAIL fill_overflow: ovf=%b count=%0d required 1 4", bus.overflow, bus.count);
        else n_pass++;
        drain(4);
        n_chk++;
        if ({bus.count, bus.overflow} !== {3'd0, 1'b1})
            $display("FAIL fill_sticky: count=%0d ovf=%b required 0 1", bus.count, bus.overflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic took;
        for (int i = 0; i < 3; i++) send_word(8'h40 + 8'(i), took);
        n_chk++;
        if (bus.count !== 3'd3) $display("FAIL mid_pre: count=%0d required 3", bus.count);
        else n_pass++;
        bus.din = 8'h77;
        bus.valid_in = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        n_chk++;
        if ({bus.count, bus.dout_valid, bus.overflow} !== {3'd0, 1'b0, 1'b0})
            $display("FAIL mid_reset: count=%0d dv=%b ovf=%b required 0 0 0", bus.count, bus.dout_valid, bus.overflow);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if ({bus.count, bus.take} !== {3'd0, 1'b0})
                $display("FAIL mid_held_high[%0d]: count=%0d take=%b required 0 0", i, bus.count, bus.take);
            else n_pass++;
        end
        bus.valid_in = 1'b0;
        repeat (3) tick();
        exp_q.push_back(8'h33);
        send_word(8'h33, took);
        n_chk++;
        if ({took, bus.count} !== {1'b1, 3'd1})
            $display("FAIL mid_recover: take=%b count=%0d required 1 1", took, bus.count);
        else n_pass++;
        drain(1);
    endtask

    task automatic test_full_pop();
        logic took;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_word(8'h10 + 8'(i), took);
        end
        n_chk++;
        if ({bus.full, bus.count} !== {1'b1, 3'd4})
            $display("FAIL fullpop_pre: full=%b count=%0d required 1 4", bus.full, bus.count);
        else n_pass++;
        bus.din = 8'h14;
        bus.valid_in = 1'b1;
        exp_q.push_back(8'h14);
        repeat (2) tick();
        n_chk++;
        if (bus.dout !== exp_q[0]) $display("FAIL fullpop_head: dout=%h required %h", bus.dout, exp_q[0]);
        else begin
            n_pass++;
            void'(exp_q.pop_front());
        end
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        n_chk++;
        if ({bus.take, bus.count, bus.overflow} !== {1'b1, 3'd4, 1'b0})
            $display("FAIL fullpop_capture: take=%b count=%0d ovf=%b required 1 4 0", bus.take, bus.count, bus.overflow);
        else n_pass++;
        bus.valid_in = 1'b0;
        repeat (3) tick();
        drain(4);
    endtask

    task automatic test_wrap();
        logic took;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(8'h20 + 8'(i));
            send_word(8'h20 + 8'(i), took);
            n_chk++;
            if (bus.count !== 3'd1) $display("FAIL wrap_count[%0d]: count=%0d required 1", i, bus.count);
            else n_pass++;
            drain(1);
        end
        bus.dout_ready = 1'b1;
        repeat (3) tick();
        bus.dout_ready = 1'b0;
        n_chk++;
        if ({bus.count, bus.dout_valid} !== {3'd0, 1'b0})
            $display("FAIL empty_pop: count=%0d dv=%b required 0 0", bus.count, bus.dout_valid);
        else n_pass++;
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.din = 8'h00;
        bus.dout_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_reset_mid();
        test_full_pop();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/inputport_rx.md
Name: inputport_rx

Overview:
- Synchronous receive stage directly downstream of the asynchronous input port.
- Consumes the port's `valid` level and its bundled data word in the `clk_inputport` domain.
- Synchronises and edge-detects `valid`, then captures each word into a small first-word-fall-through (FWFT) FIFO. Captured words are presented to core logic through a valid/ready interface.
- Reports each capture upstream with a one-cycle `take` pulse and flags any word lost to overflow.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, FIFO entries; a power of 2, at least 2.
- CW, 3, count width; must equal log2(DEPTH)+1.

Ports:
- clk_inputport  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk_inputport.
- valid_in  input  1  asynchronous valid level from the input port; a new word is flagged by each 0->1 transition.
- din  input  WIDTH  bundled data; stable from before the valid_in rise until valid_in falls.
- take  output  1  one-cycle pulse marking a capture attempt.
- dout  output  WIDTH  head-of-FIFO word.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- count  output  CW  number of words held, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when a word is dropped.

Behaviour:
- Reset (reset == 0 at an edge): clears
  - sync flops s1, s2 and delayed copy s2_d;
  - FIFO pointers and count;
  - take, overflow, dout_valid, full.
  - dout is held at 0 while empty.
  - Reset mid-transfer discards all buffered words and any pending edge.
- Synchroniser:
  - s1 <= valid_in, s2 <= s1, s2_d <= s2.
  - cap = s2 & ~s2_d is a combinational rising-edge detect.
- Latency: if valid_in rises before edge E0:
  - s1 = 1 after E0, s2 = 1 after E1, cap is high in the cycle following E1;
  - the word is written at E2;
  - take = 1 and dout_valid = 1 (if the FIFO was empty) in the cycle after E2.
  - Total: 2 edges from synchronised valid to visible data.
- Capture:
  - On an edge with cap = 1, din is written at the write pointer.
  - din is sampled at that edge; the bundled-data rule guarantees it is stable there.
- take: registered, equals cap delayed by one edge. Exactly one pulse per valid_in rise, asserted whether or not the word was stored.
- Pop: dout_valid && dout_ready at an edge advances the read pointer.
- count update per edge:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop.
- Full:
  - cap while full with no pop: word dropped, pointers unchanged, overflow <= 1.
  - cap while full with a pop in the same edge: push accepted, no overflow.
- Empty: dout_ready while empty has no effect; count never underflows.
- overflow clears only on reset.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
- FWFT: dout = mem[rd_ptr] whenever dout_valid = 1.
- Ordering: strict FIFO order.
- valid_in pulses shorter than 2 clock periods are not guaranteed to be detected. Upstream holds valid_in at each level for at least 3 clock periods.

Test Plan:
- Reset then idle: reset = 0 for 2 cycles then 1, valid_in = 0 -> count = 0, dout_valid = 0, take = 0, overflow = 0 for 20 cycles.
- Single word: din = 8'hA5, valid_in rises before E0 -> take pulses 1 cycle after E2; dout = A5, dout_valid = 1, count = 1. dout_ready = 1 one cycle -> count = 0.
- Fill and overflow (DEPTH = 4): push 8'h01..8'h05 with dout_ready = 0 -> full = 1 after the 4th push. 5th push: take still pulses, overflow = 1, count = 4. Draining yields 01, 02, 03, 04.
- Push while full with pop: FIFO full holding 10..13, 5th valid_in rise with dout_ready = 1 at the capture edge -> overflow stays 0, count stays 4. Pop order is 10, 11, 12, 13, 14.
- Wrap-around: 10 push/pop pairs of 8'h20..8'h29 through DEPTH = 4 -> output sequence identical to input, count never exceeds 4.
- Reset mid-operation: 3 words buffered and valid_in high, reset = 0 for 1 edge -> count = 0, dout_valid = 0, overflow = 0. valid_in still high afterwards causes no capture until its next 0->1 transition.
